// File: rtl/md_hilo_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   md_op_e    : MdOpE encodings (mult, multu, div, divu)
//   SEL_LO/HI  : HiLoE select values for mthi/mtlo and mfhi/mflo
//   md_state_e : sequencer state encoding
//   CNT_W      : latency counter width (latencies 1..15)
package md_hilo_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/md_hilo_ctrl_if.sv
// EX/D-stage bundle between the pipeline and the HI/LO sequencer.
//   master : pipeline side, drives start/operands/mthi-mtlo/decode use
//   slave  : sequencer side, returns busy, stall request and HI/LO values
interface md_hilo_ctrl_if;
  logic        StartE;
  logic [1:0]  MdOpE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        HiLoWriteE;
  logic        HiLoE;
  logic        MdUseD;
  logic        BusyE;
  logic        StallMdD;
  logic [31:0] HiE;
  logic [31:0] LoE;
  logic [31:0] HiLoOutE;

  modport master (
    output StartE, MdOpE, SrcAE, SrcBE, HiLoWriteE, HiLoE, MdUseD,
    input  BusyE, StallMdD, HiE, LoE, HiLoOutE
  );

  modport slave (
    input  StartE, MdOpE, SrcAE, SrcBE, HiLoWriteE, HiLoE, MdUseD,
    output BusyE, StallMdD, HiE, LoE, HiLoOutE
  );
endinterface

// File: rtl/md_hilo_ctrl_arith.sv
// Combinational 32x32 multiply/divide datapath.
//   op  : operation (md_op_e)
//   a,b : rs / rt operands
//   res : {hi, lo}; multiplies give the 64-bit product, divides give
//         {remainder, quotient}
// Divide by zero yields lo = all ones, hi = dividend. The signed overflow
// case 0x80000000 / -1 yields lo = 0x80000000, hi = 0. Both are resolved
// explicitly so the '/' and '%' operators never see those operands.
module md_arith
  import md_hilo_ctrl_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic signed [63:0] sa64;
  logic signed [63:0] sb64;
  logic signed [31:0] sq;
  logic signed [31:0] sr;

  always_comb begin
    res  = '0;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sq   = '0;
    sr   = '0;
    case (op)
      MD_MULT:  res = sa64 * sb64;
      MD_MULTU: res = {32'h0, a} * {32'h0, b};
      MD_DIV: begin
        if (b == 32'h0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          sq  = $signed(a) / $signed(b);
          sr  = $signed(a) % $signed(b);
          res = {sr, sq};
        end
      end
      MD_DIVU: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_hilo_ctrl.sv
// Multi-cycle multiply/divide sequencer and HI/LO register owner (EX stage).
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : slave side of md_hilo_ctrl_if
//              StartE/MdOpE/SrcAE/SrcBE start an operation,
//              HiLoWriteE/HiLoE perform mthi/mtlo, MdUseD flags a D-stage user,
//              BusyE/StallMdD/HiE/LoE/HiLoOutE report back.
// The result is computed and latched when the start is sampled; the counter
// then only times the commit to HI/LO, BusyE being high for exactly N cycles.
module md_hilo_ctrl
  import md_hilo_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic          clk,
  input logic          rst,
  md_hilo_ctrl_if.slave bus
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("md_hilo_ctrl: MUL_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("md_hilo_ctrl: DIV_CYCLES must be in 1..15");
  end

  md_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [63:0]      pend, pend_n;
  logic [31:0]      hi, hi_n;
  logic [31:0]      lo, lo_n;
  logic [63:0]      arith_res;

  md_arith u_arith (
    .op  (md_op_e'(bus.MdOpE)),
    .a   (bus.SrcAE),
    .b   (bus.SrcBE),
    .res (arith_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      ST_IDLE: begin
        // Start has priority over a same-cycle mthi/mtlo.
        if (bus.StartE) begin
          state_n = ST_RUN;
          cnt_n   = bus.MdOpE[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          pend_n  = arith_res;
        end else if (bus.HiLoWriteE) begin
          if (bus.HiLoE == SEL_HI) hi_n = bus.SrcAE;
          else                     lo_n = bus.SrcAE;
        end
      end
      ST_RUN: begin
        // Starts and mthi/mtlo arriving while busy are dropped.
        if (cnt == CNT_W'(1)) begin
          hi_n    = pend[63:32];
          lo_n    = pend[31:0];
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.BusyE    = (state == ST_RUN);
  assign bus.StallMdD = bus.MdUseD & (bus.BusyE | bus.StartE);
  assign bus.HiE      = hi;
  assign bus.LoE      = lo;
  assign bus.HiLoOutE = (bus.HiLoE == SEL_HI) ? hi : lo;

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Directed bench for md_hilo_ctrl: reset, each arithmetic op, divide corner
// cases, stall timing, mthi/mtlo, illegal requests while busy, start/write
// priority and asynchronous reset during an operation.
module tb_md_hilo_ctrl;
  import md_hilo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  md_hilo_ctrl_if bus();

  md_hilo_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic illegal_seen = 1'b0;

  // Flags any start or mthi/mtlo request sampled while the unit is busy.
  always @(posedge clk)
    if (bus.BusyE === 1'b1 && (bus.StartE === 1'b1 || bus.HiLoWriteE === 1'b1))
      illegal_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.StartE     = 1'b0;
    bus.MdOpE      = 2'b00;
    bus.SrcAE      = '0;
    bus.SrcBE      = '0;
    bus.HiLoWriteE = 1'b0;
    bus.HiLoE      = SEL_LO;
    bus.MdUseD     = 1'b0;
  endtask

  // Issues one operation and follows it through its busy window to commit.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int unsigned n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic use_d);
    bus.StartE = 1'b1;
    bus.MdOpE  = op;
    bus.SrcAE  = a;
    bus.SrcBE  = b;
    bus.MdUseD = use_d;
    #1;
    check({tag, ".stall_start"}, 32'(bus.StallMdD), 32'(use_d));
    tick;
    bus.StartE = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, ".busy"}, 32'(bus.BusyE), 32'd1);
      check({tag, ".stall_busy"}, 32'(bus.StallMdD), 32'(use_d));
      tick;
    end
    check({tag, ".busy_done"}, 32'(bus.BusyE), 32'd0);
    check({tag, ".stall_done"}, 32'(bus.StallMdD), 32'd0);
    check({tag, ".hi"}, bus.HiE, exp_hi);
    check({tag, ".lo"}, bus.LoE, exp_lo);
    bus.MdUseD = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    check("reset.hi", bus.HiE, 32'h0);
    check("reset.lo", bus.LoE, 32'h0);
    check("reset.busy", 32'(bus.BusyE), 32'd0);
    check("reset.stall", 32'(bus.StallMdD), 32'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("idle.busy", 32'(bus.BusyE), 32'd0);
    check("idle.hi", bus.HiE, 32'h0);

    run_op("mult",  MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0", MD_DIVU,  32'h1234_5678, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op("divov", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // -1 * 6 with a decode-stage user held: stall through the whole window.
    run_op("mult_use", MD_MULT, 32'hFFFF_FFFF, 32'd6, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    bus.HiLoE = SEL_LO;
    #1;
    check("hilo_out.lo", bus.HiLoOutE, 32'hFFFF_FFFA);
    bus.HiLoE = SEL_HI;
    #1;
    check("hilo_out.hi", bus.HiLoOutE, 32'hFFFF_FFFF);

    // mthi then mtlo while idle.
    bus.HiLoWriteE = 1'b1;
    bus.HiLoE      = SEL_HI;
    bus.SrcAE      = 32'hDEAD_BEEF;
    #1;
    check("mthi.before", bus.HiE, 32'hFFFF_FFFF);
    tick;
    bus.HiLoE = SEL_LO;
    bus.SrcAE = 32'h0BAD_F00D;
    check("mthi.hi", bus.HiE, 32'hDEAD_BEEF);
    check("mthi.lo_kept", bus.LoE, 32'hFFFF_FFFA);
    tick;
    bus.HiLoWriteE = 1'b0;
    check("mtlo.lo", bus.LoE, 32'h0BAD_F00D);
    check("mtlo.hi_kept", bus.HiE, 32'hDEAD_BEEF);

    // divu 100/7 with an mthi and a mult start issued mid-operation.
    check("illegal.clear", 32'(illegal_seen), 32'd0);
    bus.StartE = 1'b1;
    bus.MdOpE  = MD_DIVU;
    bus.SrcAE  = 32'd100;
    bus.SrcBE  = 32'd7;
    tick;                       // edge k
    bus.StartE = 1'b0;
    tick;                       // k+1
    tick;                       // k+2
    bus.HiLoWriteE = 1'b1;
    bus.HiLoE      = SEL_HI;
    bus.SrcAE      = 32'h5555_5555;
    tick;                       // k+3
    bus.HiLoWriteE = 1'b0;
    check("run_mthi.hi_kept", bus.HiE, 32'hDEAD_BEEF);
    bus.StartE = 1'b1;
    bus.MdOpE  = MD_MULT;
    bus.SrcAE  = 32'd3;
    bus.SrcBE  = 32'd3;
    tick;                       // k+4
    bus.StartE = 1'b0;
    check("run_illegal.flag", 32'(illegal_seen), 32'd1);
    repeat (5) tick;            // k+9
    check("run_ign.busy_k9", 32'(bus.BusyE), 32'd1);
    tick;                       // k+10
    check("run_ign.busy_k10", 32'(bus.BusyE), 32'd0);
    check("run_ign.hi", bus.HiE, 32'd2);
    check("run_ign.lo", bus.LoE, 32'd14);

    // Start and mtlo together: the start wins, LO is not written directly.
    bus.StartE     = 1'b1;
    bus.MdOpE      = MD_MULTU;
    bus.SrcAE      = 32'd5;
    bus.SrcBE      = 32'd1;
    bus.HiLoWriteE = 1'b1;
    bus.HiLoE      = SEL_LO;
    tick;
    bus.StartE     = 1'b0;
    bus.HiLoWriteE = 1'b0;
    check("start_wins.lo_kept", bus.LoE, 32'd14);
    check("start_wins.busy", 32'(bus.BusyE), 32'd1);
    repeat (5) tick;
    check("start_wins.lo", bus.LoE, 32'd5);
    check("start_wins.hi", bus.HiE, 32'd0);

    // Asynchronous reset in the middle of a multiply.
    bus.StartE = 1'b1;
    bus.MdOpE  = MD_MULT;
    bus.SrcAE  = 32'd7;
    bus.SrcBE  = 32'd6;
    tick;
    bus.StartE = 1'b0;
    tick;
    check("rst_mid.busy_before", 32'(bus.BusyE), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid.busy", 32'(bus.BusyE), 32'd0);
    check("rst_mid.hi", bus.HiE, 32'h0);
    check("rst_mid.lo", bus.LoE, 32'h0);
    tick;
    rst = 1'b0;
    repeat (6) tick;
    check("rst_mid.no_commit", bus.LoE, 32'h0);
    check("rst_mid.idle", 32'(bus.BusyE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_hilo_ctrl.md
Name: md_hilo_ctrl

Overview:
- Multi-cycle multiply/divide sequencer and owner of the HI/LO register pair, sitting in the EX stage behind the ID/EX pipeline register.
- Accepts mult/multu/div/divu starts and mthi/mtlo writes from EX.
- Counts out the fixed operation latency and commits results to HI/LO.
- Raises a stall request to the hazard unit while any decode-stage instruction needs the unit or HI/LO before it is free.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- StartE  in  1  EX instruction is mult/multu/div/divu
- MdOpE  in  2  00 mult, 01 multu, 10 div, 11 divu
- SrcAE  in  32  forwarded rs operand
- SrcBE  in  32  forwarded rt operand
- HiLoWriteE  in  1  EX instruction is mthi/mtlo
- HiLoE  in  1  select for mthi/mtlo and for HiLoOutE read: 1 HI, 0 LO
- MdUseD  in  1  D-stage instruction is a md op, mthi/mtlo or mfhi/mflo
- BusyE  out  1  operation in progress
- StallMdD  out  1  stall request to hazard unit
- HiE  out  32  current HI
- LoE  out  32  current LO
- HiLoOutE  out  32  HiE if HiLoE else LoE (for mfhi/mflo)

Behaviour:
- Reset (async, immediate):
  - state IDLE, counter 0, pending results 0.
  - HiE = LoE = 0, BusyE = 0.
  - StallMdD is combinational and follows its equation, so it reads 0 while MdUseD = 0.
- States:
  - IDLE to RUN: on a clk edge with StartE = 1. Load counter with MUL_CYCLES (MdOpE[1] = 0) or DIV_CYCLES (MdOpE[1] = 1). Compute and latch the 64-bit result into pending {hi, lo}.
  - RUN: decrement the counter each edge. On the edge where the counter equals 1, write pending hi to HiE and pending lo to LoE, and return to IDLE.
- BusyE = (state == RUN).
  - With start sampled at edge k, BusyE is high for exactly N cycles after edge k.
  - New HI/LO values are visible in the same cycle BusyE falls (after edge k+N).
- Arithmetic:
  - mult: signed 32x32 to 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 to 64.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (SrcBE = 0): lo = 32'hFFFFFFFF, hi = SrcAE. No trap.
  - Signed overflow (0x80000000 / -1): lo = 0x80000000, hi = 0.
- mthi/mtlo: with HiLoWriteE = 1 in IDLE, write SrcAE into HI (HiLoE = 1) or LO (HiLoE = 0) at the edge; visible the next cycle.
- StallMdD = MdUseD & (BusyE | StartE). This covers the back-to-back case where the md op is in EX this cycle.
- Illegal or simultaneous events:
  - StartE or HiLoWriteE while BusyE = 1: ignored, no state change. The hazard unit guarantees this cannot happen; the bench asserts it.
  - StartE and HiLoWriteE together: StartE wins.
- Pipeline flush: there is no flush input. Once sampled, an operation always completes, because a flushed EX slot arrives with StartE = 0.
- Reset mid-operation: abort immediately, pending result discarded, HI/LO = 0.
- Zero-latency commit is not supported. N ≥ 1 is enforced by an elaboration check.

Decomposition:
- Shared package holds:
  - MdOp encodings (MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11)
  - HI/LO select constants
  - state encoding (ST_IDLE, ST_RUN)
- One combinational sub-module, md_arith, computes the 64-bit {hi, lo} result from MdOp, A and B, including the divide-by-zero and overflow rules.
- The sequencing, counter, HI/LO registers and stall logic live in the top.

Test Plan:
- Reset then idle → HiE = LoE = 0, BusyE = 0. Assert rst mid-RUN → BusyE drops asynchronously and HiE = LoE = 0.
- mult A = 0xFFFFFFFE (-2), B = 3 → BusyE high 5 cycles. Then HiE = 0xFFFFFFFF, LoE = 0xFFFFFFFA. multu with the same operands → HiE = 0x00000002, LoE = 0xFFFFFFFA.
- div A = -7 (0xFFFFFFF9), B = 2 → BusyE high 10 cycles. Then LoE = 0xFFFFFFFD (-3), HiE = 0xFFFFFFFF (-1).
- divu A = 0x12345678, B = 0 → LoE = 0xFFFFFFFF, HiE = 0x12345678. div 0x80000000 / 0xFFFFFFFF → LoE = 0x80000000, HiE = 0.
- Start a mult with MdUseD = 1 held → StallMdD = 1 in the start cycle and all 5 busy cycles, 0 in the cycle BusyE falls. HiLoOutE then shows the new LO with HiLoE = 0.
- mthi 0xDEADBEEF and mtlo 0x0BADF00D in IDLE → HiE/LoE updated next cycle. mthi issued during RUN → ignored and the assertion fires.
